seg_display_arbiter: RTL and testbench
======================================

Name: seg_display_arbiter

Overview:
Shares the single 8-digit seven-segment display between NUM_SRC independent requesters, e.g. note decoder, tempo counter and debug/status.
Each requester posts a 32-bit hex word plus a digit-enable mask. The block latches requests, chooses a winner by fixed priority, blanks briefly between different sources, and holds each winner for a minimum on-screen time.
Outputs drive seven_segment_controller val_in directly; digit_mask_out is ANDed (active-high) with the per-digit enables ahead of the anode inversion.

Parameters:
NUM_SRC, 4, number of requesters, legal range 2..8; index 0 has the highest priority.
HOLD_CYCLES, 50_000_000, minimum cycles a granted source stays displayed; must be >= 1.
BLANK_CYCLES, 5_000_000, cycles of all-digits-off inserted when the display switches source; must be >= 1.

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-high reset
req_valid_in  input  NUM_SRC  one-cycle request strobe per source
req_data_in  input  32*NUM_SRC  source i word in bits [32i+31:32i]
req_mask_in  input  8*NUM_SRC  source i digit enables in bits [8i+7:8i]; bit d = digit d
val_out  output  32  word presented to seven_segment_controller
digit_mask_out  output  8  per-digit enable, 1 = digit lit
active_src_out  output  3  index of the source currently owning the display
req_ack_out  output  NUM_SRC  one-cycle pulse when source i is granted
busy_out  output  1  high in BLANK or HOLD

Behaviour:
- Reset (async assert, clk_in-synchronous release):
  - val_out=0, digit_mask_out=8'h00, active_src_out=0, req_ack_out=0, busy_out=0.
  - State IDLE; shown_flag=0; all shadow words, shadow masks and pending flags cleared.
  - Reset mid-BLANK or mid-HOLD aborts immediately and discards all pending requests.
- Capture: every cycle, for each i with req_valid_in[i]=1, shadow_data[i] and shadow_mask[i] load from the inputs.
  - pending[i] is set on the next edge, except in the HOLD live-update case below.
  - Repeated strobes before grant overwrite the shadow; only the last one is displayed.
- Arbitration: evaluated in IDLE only, over registered pending[] (not raw strobes). Winner g = lowest index with pending set.
- State IDLE:
  - No pending: outputs hold their last values indefinitely; busy_out=0.
  - Winner g, with g==active_src_out and shown_flag=1:
    - next edge: val_out<=shadow_data[g], digit_mask_out<=shadow_mask[g], clear pending[g];
    - req_ack_out[g]=1 for one cycle; go to HOLD with counter=0. No blanking.
  - Any other winner:
    - next edge: digit_mask_out<=0, active_src_out<=g, clear pending[g];
    - req_ack_out[g]=1 for one cycle; go to BLANK with counter=0.
- State BLANK:
  - val_out is unchanged; mask stays 0.
  - After exactly BLANK_CYCLES cycles in BLANK: load val_out/digit_mask_out from shadow[g], set shown_flag=1, go to HOLD with counter=0.
- State HOLD:
  - Lasts HOLD_CYCLES cycles, then IDLE with the display left as is.
  - No preemption: higher-priority requests stay pending until HOLD ends.
  - Live update: req_valid_in[active_src_out] during HOLD updates val_out/digit_mask_out on the next edge and restarts the counter at 0. pending is not set; no extra ack.
- Simultaneous events:
  - A strobe from g in the same cycle its pending is cleared leaves pending[g]=1, and the newer data is shown later.
  - Multiple strobes in one cycle are all captured.
- Latency from a strobe at cycle t, block idle, different source:
  - ack in cycle t+2; mask=0 for cycles t+2 .. t+1+BLANK_CYCLES;
  - new value visible from cycle t+2+BLANK_CYCLES.
- Counters are 32-bit, compared against parameter-1, and never wrap in normal operation.
- req_ack_out is registered and at most one bit is high per cycle.

Test Plan:
- Bench parameters for all cases: NUM_SRC=4, HOLD_CYCLES=8, BLANK_CYCLES=2.
- Reset, then src2 strobe data=32'h0000_1234, mask=8'h0F at cycle 0 -> ack[2] at cycle 2; mask=0 in cycles 2-3; val_out=32'h1234, mask=8'h0F, active_src=2 from cycle 4; IDLE after cycle 11.
- During src2 HOLD, src0 and src3 strobe in the same cycle -> no change until HOLD ends; then src0 is granted (ack[0], blank, display); src3 is granted only after src0's HOLD.
- During src1 HOLD at counter=5, src1 strobes 32'hABCD -> val_out=32'hABCD next cycle; HOLD extends to 8 cycles from the update; no ack, no blank.
- src1 is displayed and IDLE; src1 strobes again -> ack[1] and direct HOLD with the new value; digit_mask_out never goes to 0.
- rst_in asserted asynchronously mid-BLANK with src3 pending -> val_out=0, mask=0 immediately, without waiting for a clock edge; after release, no grant occurs without a new strobe.

Source files
------------

// File: rtl/seg_display_arbiter_if.sv
// Bundles the requester-side strobes and the display-side outputs of seg_display_arbiter.
interface seg_display_arbiter_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0]   req_valid_in;
    logic [32*NUM_SRC-1:0] req_data_in;
    logic [8*NUM_SRC-1:0]  req_mask_in;
    logic [31:0]          val_out;
    logic [7:0]           digit_mask_out;
    logic [2:0]           active_src_out;
    logic [NUM_SRC-1:0]   req_ack_out;
    logic                 busy_out;

    modport master (
        output req_valid_in, req_data_in, req_mask_in,
        input  val_out, digit_mask_out, active_src_out, req_ack_out, busy_out
    );

    modport slave (
        input  req_valid_in, req_data_in, req_mask_in,
        output val_out, digit_mask_out, active_src_out, req_ack_out, busy_out
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// Fixed-priority sharing of one 8-digit seven-segment display between NUM_SRC requesters,
// with a blank gap on source changes and a minimum on-screen hold per grant.
module seg_display_arbiter #(
    parameter int NUM_SRC      = 4,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int BLANK_CYCLES = 5_000_000
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    seg_display_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BLANK, HOLD} state_t;

    state_t                   state_q, state_d;
    logic [NUM_SRC-1:0][31:0] shadow_data;
    logic [NUM_SRC-1:0][7:0]  shadow_mask;
    logic [NUM_SRC-1:0]       pending, clr, live_hit, ack_d, ack_q;
    logic [31:0]              cnt_q, cnt_d, val_q, val_d;
    logic [7:0]               mask_q, mask_d;
    logic [2:0]               act_q, act_d, win;
    logic                     win_vld, shown_q, shown_d, live;
    logic [31:0]              win_data, act_data, live_data;
    logic [7:0]               win_mask, act_mask, live_mask;

    // Per-source capture; a live update of the shown source does not queue a new grant.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
        assign live_hit[i] = (state_q == HOLD) && bus.req_valid_in[i] && (act_q == 3'(i));

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                shadow_data[i] <= '0;
                shadow_mask[i] <= '0;
                pending[i]     <= 1'b0;
            end else begin
                if (bus.req_valid_in[i]) begin
                    shadow_data[i] <= bus.req_data_in[32*i +: 32];
                    shadow_mask[i] <= bus.req_mask_in[8*i +: 8];
                end
                pending[i] <= (pending[i] & ~clr[i]) | (bus.req_valid_in[i] & ~live_hit[i]);
            end
        end
    end

    assign live = |live_hit;

    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending[i]) begin
                win     = 3'(i);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        win_data  = '0;
        win_mask  = '0;
        act_data  = '0;
        act_mask  = '0;
        live_data = '0;
        live_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (win == 3'(i)) begin
                win_data = shadow_data[i];
                win_mask = shadow_mask[i];
            end
            if (act_q == 3'(i)) begin
                act_data  = shadow_data[i];
                act_mask  = shadow_mask[i];
                live_data = bus.req_data_in[32*i +: 32];
                live_mask = bus.req_mask_in[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        val_d   = val_q;
        mask_d  = mask_q;
        act_d   = act_q;
        shown_d = shown_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (win_vld) begin
                    for (int i = 0; i < NUM_SRC; i++)
                        if (win == 3'(i)) clr[i] = 1'b1;
                    // Re-grant of the source already on screen skips the blank gap.
                    if (win == act_q && shown_q) begin
                        val_d   = win_data;
                        mask_d  = win_mask;
                        state_d = HOLD;
                    end else begin
                        mask_d  = '0;
                        act_d   = win;
                        state_d = BLANK;
                    end
                end
            end
            BLANK: begin
                if (cnt_q == 32'(BLANK_CYCLES - 1)) begin
                    val_d   = act_data;
                    mask_d  = act_mask;
                    shown_d = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (live) begin
                    val_d  = live_data;
                    mask_d = live_mask;
                    cnt_d  = '0;
                end else if (cnt_q == 32'(HOLD_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        ack_d = clr;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            val_q   <= '0;
            mask_q  <= '0;
            act_q   <= '0;
            ack_q   <= '0;
            shown_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            mask_q  <= mask_d;
            act_q   <= act_d;
            ack_q   <= ack_d;
            shown_q <= shown_d;
        end
    end

    assign bus.val_out        = val_q;
    assign bus.digit_mask_out = mask_q;
    assign bus.active_src_out = act_q;
    assign bus.req_ack_out    = ack_q;
    assign bus.busy_out       = (state_q != IDLE);
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed and random checks of seg_display_arbiter against a deadline-based reference model.
module tb_seg_display_arbiter;
    localparam int NS = 4;
    localparam int H  = 8;
    localparam int B  = 2;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    seg_display_arbiter_if #(.NUM_SRC(NS)) bus ();

    seg_display_arbiter #(.NUM_SRC(NS), .HOLD_CYCLES(H), .BLANK_CYCLES(B)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (bus)
    );

    int vecs = 0;
    int errs = 0;

    // Reference model: phases end at absolute edge numbers rather than via a counter.
    int          n_edge, act, m_ack, phase, dl;
    logic [31:0] sh_d[NS];
    logic [7:0]  sh_m[NS];
    bit          pend[NS];
    bit          shown;
    logic [31:0] m_val;
    logic [7:0]  m_mask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        n_edge = 0; act = 0; m_ack = -1; phase = 0; dl = 0;
        shown = 0; m_val = '0; m_mask = '0;
        for (int i = 0; i < NS; i++) begin
            sh_d[i] = '0; sh_m[i] = '0; pend[i] = 0;
        end
    endtask

    task automatic model_edge(input logic [NS-1:0] v, input logic [32*NS-1:0] d,
                              input logic [8*NS-1:0] m);
        int g, a0;
        bit live;
        n_edge++;
        a0    = act;
        live  = (phase == 2) && v[a0];
        m_ack = -1;
        g     = -1;
        for (int i = NS - 1; i >= 0; i--) if (pend[i]) g = i;
        case (phase)
            0: if (g >= 0) begin
                m_ack   = g;
                pend[g] = 0;
                if (g == act && shown) begin
                    m_val = sh_d[g]; m_mask = sh_m[g]; phase = 2; dl = n_edge + H;
                end else begin
                    m_mask = '0; act = g; phase = 1; dl = n_edge + B;
                end
            end
            1: if (n_edge == dl) begin
                m_val = sh_d[act]; m_mask = sh_m[act]; shown = 1; phase = 2; dl = n_edge + H;
            end
            default: begin
                if (live) begin
                    m_val = d[32*a0 +: 32]; m_mask = m[8*a0 +: 8]; dl = n_edge + H;
                end else if (n_edge == dl) phase = 0;
            end
        endcase
        for (int i = 0; i < NS; i++) begin
            if (v[i]) begin
                sh_d[i] = d[32*i +: 32];
                sh_m[i] = m[8*i +: 8];
                if (!(live && i == a0)) pend[i] = 1;
            end
        end
    endtask

    task automatic compare_all();
        logic [NS-1:0] exp_ack;
        exp_ack = '0;
        if (m_ack >= 0) exp_ack[m_ack] = 1'b1;
        chk("val",    bus.val_out,                  m_val);
        chk("mask",   {24'd0, bus.digit_mask_out},  {24'd0, m_mask});
        chk("active", {29'd0, bus.active_src_out},  32'(act));
        chk("ack",    {28'd0, bus.req_ack_out},     {28'd0, exp_ack});
        chk("busy",   {31'd0, bus.busy_out},        {31'd0, phase != 0});
    endtask

    task automatic step(input logic [NS-1:0] v, input logic [32*NS-1:0] d,
                        input logic [8*NS-1:0] m);
        bus.req_valid_in = v;
        bus.req_data_in  = d;
        bus.req_mask_in  = m;
        @(posedge clk_in);
        model_edge(v, d, m);
        #1;
        compare_all();
        bus.req_valid_in = '0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step('0, '0, '0);
    endtask

    task automatic strobe1(input int s, input logic [31:0] data, input logic [7:0] mask);
        logic [NS-1:0]    v;
        logic [32*NS-1:0] d;
        logic [8*NS-1:0]  m;
        v = '0; d = '0; m = '0;
        v[s] = 1'b1; d[32*s +: 32] = data; m[8*s +: 8] = mask;
        step(v, d, m);
    endtask

    initial begin
        logic [NS-1:0]    v;
        logic [32*NS-1:0] d;
        logic [8*NS-1:0]  m;
        bus.req_valid_in = '0;
        bus.req_data_in  = '0;
        bus.req_mask_in  = '0;
        model_reset();
        #12;
        chk("rst_val",  bus.val_out, 32'h0);
        chk("rst_mask", {24'd0, bus.digit_mask_out}, 32'h0);
        chk("rst_busy", {31'd0, bus.busy_out}, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b0;
        idle(3);

        // Cycle 0 strobe from src2; observations after each step are cycles 1, 2, ...
        strobe1(2, 32'h0000_1234, 8'h0F);
        for (int c = 2; c <= 12; c++) begin
            step('0, '0, '0);
            if (c == 2) chk("s1_ack", {28'd0, bus.req_ack_out}, 32'h4);
            if (c == 2 || c == 3) chk("s1_blank", {24'd0, bus.digit_mask_out}, 32'h0);
            if (c == 4) begin
                chk("s1_val", bus.val_out, 32'h1234);
                chk("s1_mask", {24'd0, bus.digit_mask_out}, 32'h0F);
                chk("s1_act", {29'd0, bus.active_src_out}, 32'd2);
            end
            if (c == 11) chk("s1_busy11", {31'd0, bus.busy_out}, 32'd1);
            if (c == 12) chk("s1_idle12", {31'd0, bus.busy_out}, 32'd0);
        end

        // src2 re-grant goes straight to HOLD; src0 and src3 strobe together mid-hold.
        strobe1(2, 32'h0000_2222, 8'hFF);
        idle(3);
        v = 4'b1001; d = '0; m = '0;
        d[31:0] = 32'h0000_000A; d[127:96] = 32'h0000_0333; m[7:0] = 8'h03; m[31:24] = 8'hF0;
        step(v, d, m);
        step('0, '0, '0);
        chk("s2_nopreempt", {29'd0, bus.active_src_out}, 32'd2);
        idle(50);

        // src1 granted with blank, then live-updated at HOLD counter 5.
        strobe1(1, 32'h0000_1111, 8'h11);
        idle(8);
        strobe1(1, 32'h0000_ABCD, 8'h3C);
        chk("s3_live_val", bus.val_out, 32'hABCD);
        chk("s3_live_noack", {28'd0, bus.req_ack_out}, 32'h0);
        idle(20);

        // Displayed, idle src1 strobes again: direct hold, never blank.
        strobe1(1, 32'h0000_5555, 8'h81);
        for (int c = 0; c < 12; c++) begin
            step('0, '0, '0);
            chk("s4_lit", {31'd0, bus.digit_mask_out != 8'h00}, 32'd1);
        end
        idle(4);

        // src0 and src3 strobe; reset lands mid-BLANK of src0 with src3 pending.
        v = 4'b1001; d = '0; m = '0;
        d[31:0] = 32'h0000_0F0F; d[127:96] = 32'h0000_3333; m[7:0] = 8'hFF; m[31:24] = 8'hFF;
        step(v, d, m);
        step('0, '0, '0);
        chk("s5_inblank", {31'd0, bus.busy_out}, 32'd1);
        #2;
        rst_in = 1'b1;
        #1;
        chk("s5_async_val",  bus.val_out, 32'h0);
        chk("s5_async_mask", {24'd0, bus.digit_mask_out}, 32'h0);
        model_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step('0, '0, '0);
            chk("s5_nogrant", {28'd0, bus.req_ack_out}, 32'h0);
        end

        // Random sparse strobes against the model.
        for (int c = 0; c < 800; c++) begin
            v = '0;
            for (int i = 0; i < NS; i++) begin
                v[i] = ($urandom_range(0, 7) == 0);
                d[32*i +: 32] = $urandom;
                m[8*i +: 8]   = 8'($urandom);
            end
            step(v, d, m);
        end
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
